sd_stream_sink: RTL and testbench
=================================

Name: sd_stream_sink

Overview:
- Consumer end of the online-arithmetic digit-stream interface.
- Accepts an MSD-first radix-2 signed-digit stream from any online unit's output side (multiplier, divider, subtractor) via Out_vd/Out_rd.
- Converts each frame on the fly into a conventional two's-complement fractional word and presents it on a parallel valid/ready port.
- Sits between the Newton-iteration datapath and conventional-binary logic (result capture, next-iteration seed).

Parameters:
- N_DIGITS, 8, digits per frame; also the number of fractional result bits.
- CNT_W, 4, digit counter width; must satisfy 2^CNT_W > N_DIGITS.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit_in  in  2  signed digit: 00=0, 01=+1, 11=-1, 10=illegal.
- Out_vd  in  1  upstream digit valid.
- Out_rd  out  1  sink ready to accept a digit.
- frame_clr  in  1  synchronous abort; discards the partial frame or held word.
- word_out  out  N_DIGITS+1  two's-complement result: sign bit plus N_DIGITS fraction bits; value = word_out / 2^N_DIGITS.
- word_vd  out  1  word_out valid.
- word_rd  in  1  downstream accepts word.
- digit_err  out  1  illegal digit seen in the current or held frame.

Behaviour:
- Reset (async, reset_n=0) values:
  - state=COLLECT, Out_rd=0 while in reset, word_vd=0, word_out=0, digit_err=0.
  - Q=0, QM=all-ones (-1), cnt=0.
  - Out_rd goes to 1 on the first clk edge after reset_n deasserts.
- State machine, states COLLECT and HOLD:
  - COLLECT: Out_rd=1, word_vd=0. A digit is accepted on an edge where Out_vd && Out_rd.
  - HOLD: Out_rd=0, word_vd=1, word_out stable.
- On-the-fly conversion per accepted digit d. Q and QM are N_DIGITS+1 bits; shifts discard the MSB.
  - d=+1: Q<=Q<<1|1, QM<=Q<<1|0.
  - d=0: Q<=Q<<1|0, QM<=QM<<1|1.
  - d=-1: Q<=QM<<1|1, QM<=QM<<1|0.
  - d=10 (illegal): treated as 0; digit_err<=1 (sticky until the frame is released).
- Frame completion and release:
  - cnt increments per accepted digit.
  - On acceptance when cnt==N_DIGITS-1: go to HOLD and set cnt<=0.
  - word_out<=final Q, i.e. the value including the last digit. word_vd=1 in the next cycle (latency 1 cycle after the last digit).
  - In HOLD with word_rd=1 at an edge: go to COLLECT, word_vd<=0, Q<=0, QM<=-1, digit_err<=0.
  - No same-edge bypass: minimum N_DIGITS+1 cycles per word.
- word_out holds its last value after release; it is only meaningful while word_vd=1.
- frame_clr=1 at an edge, in either state:
  - Go to COLLECT, cnt<=0, Q<=0, QM<=-1, word_vd<=0, digit_err<=0.
  - Has priority over a simultaneous digit accept (the digit is dropped) and over word_rd.
- Out_vd while in HOLD is ignored; the upstream must hold the digit.
- Representable range: results lie in -(2^N_DIGITS-1) .. +(2^N_DIGITS-1), scaled, so no overflow is possible in N_DIGITS+1 bits.
- Reset mid-frame discards all partial state immediately, asynchronously.

Test Plan:
- N_DIGITS=8, stream +1,0,0,0,0,0,0,0 with Out_vd held 1 -> word_vd rises 1 cycle after the 8th accept; word_out=9'h080 (0.5); Out_rd=0 until word_rd.
- Stream +1,-1,0,0,0,0,0,0 -> word_out=9'h040 (0.25). Stream eight -1 digits -> word_out=9'h101 (-255/256). Stream 0,0,0,0,0,0,0,-1 -> word_out=9'h1FF.
- Backpressure: word_rd=0 for 5 cycles after word_vd -> word_out and word_vd stable, Out_rd=0, upstream digits not consumed. word_rd=1 -> Out_rd=1 next cycle and the next frame converts correctly.
- Gapped input: Out_vd toggled 1/0 every cycle -> the same results as contiguous streams; cnt advances only on handshakes.
- Illegal digit 2'b10 in position 3 of an all-zero frame -> word_out=9'h000, digit_err=1 with word_vd; digit_err clears on release.
- After 3 digits: pulse frame_clr together with Out_vd -> digit dropped, next 8 digits form a clean frame. Repeat with reset_n=0 mid-frame -> all outputs 0 immediately, next frame correct.

Source files
------------

// File: rtl/sd_stream_sink.sv
// Converts an MSD-first radix-2 signed-digit stream into a two's-complement fraction (Q/QM on-the-fly conversion).
// Word valid 1 cycle after the last digit; Out_rd drops while a word is held, so upstream stalls until word_rd.
module sd_stream_sink #(
   parameter int N_DIGITS = 8,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          digit_in,
   input  logic                Out_vd,
   output logic                Out_rd,
   input  logic                frame_clr,
   output logic [N_DIGITS:0]   word_out,
   output logic                word_vd,
   input  logic                word_rd,
   output logic                digit_err
);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t              state, state_nxt;
   logic [N_DIGITS:0]   q, qm, q_nxt, qm_nxt;
   logic [N_DIGITS:0]   conv_q, conv_qm;
   logic [N_DIGITS:0]   word_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                accept, last_digit, err_nxt;

   assign accept     = Out_vd && Out_rd;
   assign last_digit = (cnt == CNT_W'(N_DIGITS - 1));

   // Q tracks the converted value, QM tracks Q - ulp, so a -1 digit never needs a borrow chain.
   always_comb begin
      conv_q  = {q[N_DIGITS-1:0], 1'b0};
      conv_qm = {qm[N_DIGITS-1:0], 1'b1};
      case (digit_in)
         2'b01: begin
            conv_q  = {q[N_DIGITS-1:0], 1'b1};
            conv_qm = {q[N_DIGITS-1:0], 1'b0};
         end
         2'b11: begin
            conv_q  = {qm[N_DIGITS-1:0], 1'b1};
            conv_qm = {qm[N_DIGITS-1:0], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      qm_nxt    = qm;
      cnt_nxt   = cnt;
      err_nxt   = digit_err;
      word_nxt  = word_out;
      if (frame_clr) begin
         state_nxt = COLLECT;
         cnt_nxt   = '0;
         q_nxt     = '0;
         qm_nxt    = '1;
         err_nxt   = 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  q_nxt  = conv_q;
                  qm_nxt = conv_qm;
                  if (digit_in == 2'b10) err_nxt = 1'b1;
                  if (last_digit) begin
                     cnt_nxt   = '0;
                     state_nxt = HOLD;
                     word_nxt  = conv_q;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (word_rd) begin
                  state_nxt = COLLECT;
                  q_nxt     = '0;
                  qm_nxt    = '1;
                  err_nxt   = 1'b0;
               end
            end
            default: state_nxt = COLLECT;
         endcase
      end
   end

   // Handshake outputs are registered from the next state so Out_rd stays low through reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= COLLECT;
         q         <= '0;
         qm        <= '1;
         cnt       <= '0;
         word_out  <= '0;
         word_vd   <= 1'b0;
         Out_rd    <= 1'b0;
         digit_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         q         <= q_nxt;
         qm        <= qm_nxt;
         cnt       <= cnt_nxt;
         word_out  <= word_nxt;
         word_vd   <= (state_nxt == HOLD);
         Out_rd    <= (state_nxt == COLLECT);
         digit_err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_sd_stream_sink.sv
// Directed bench for sd_stream_sink: reset, conversion vectors, backpressure, gaps, illegal digits, abort and reset.
module tb_sd_stream_sink;

   logic       clk;
   logic       reset_n;
   logic [1:0] digit_in;
   logic       Out_vd;
   logic       Out_rd;
   logic       frame_clr;
   logic [8:0] word_out;
   logic       word_vd;
   logic       word_rd;
   logic       digit_err;

   int asserts  = 0;
   int failures = 0;

   sd_stream_sink #(.N_DIGITS(8), .CNT_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .digit_in  (digit_in),
      .Out_vd    (Out_vd),
      .Out_rd    (Out_rd),
      .frame_clr (frame_clr),
      .word_out  (word_out),
      .word_vd   (word_vd),
      .word_rd   (word_rd),
      .digit_err (digit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sends the first n digits of a 16-bit MSD-first frame; returns on the sample point after the last accept.
   task automatic drive_digits(input logic [15:0] frame, input int n, input bit gapped,
                               output bit done, output logic vd_pre);
      int  i = 0;
      int  cyc = 0;
      bit  tog = 1'b1;
      bit  hs;
      vd_pre = 1'b0;
      while (i < n && cyc < 200) begin
         digit_in = frame[15-2*i -: 2];
         Out_vd   = gapped ? tog : 1'b1;
         hs = Out_vd && Out_rd;
         if (hs && i == n - 1) vd_pre = word_vd;
         @(posedge clk); #1;
         if (hs) i++;
         tog = ~tog;
         cyc++;
      end
      Out_vd   = 1'b0;
      digit_in = 2'b00;
      done = (i == n);
   endtask

   task automatic release_word();
      word_rd = 1'b1;
      @(posedge clk); #1;
      word_rd = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      asserts++; if (Out_rd !== 1'b0)    begin failures++; $display("FAIL rst_out_rd got %b exp 0", Out_rd); end
      asserts++; if (word_vd !== 1'b0)   begin failures++; $display("FAIL rst_word_vd got %b exp 0", word_vd); end
      asserts++; if (word_out !== 9'h0)  begin failures++; $display("FAIL rst_word_out got %h exp 000", word_out); end
      asserts++; if (digit_err !== 1'b0) begin failures++; $display("FAIL rst_digit_err got %b exp 0", digit_err); end
      @(posedge clk); #3;
      reset_n = 1'b1;
      #1;
      asserts++; if (Out_rd !== 1'b0) begin failures++; $display("FAIL rst_rd_before_edge got %b exp 0", Out_rd); end
      @(posedge clk); #1;
      asserts++; if (Out_rd !== 1'b1) begin failures++; $display("FAIL rst_rd_after_edge got %b exp 1", Out_rd); end
   endtask

   task automatic test_frames(input bit gapped);
      logic [15:0] frames [4] = '{16'h4000, 16'h7000, 16'hFFFF, 16'h0003};
      logic [8:0]  expw   [4] = '{9'h080, 9'h040, 9'h101, 9'h1FF};
      bit   done;
      logic vd_pre;
      for (int k = 0; k < 4; k++) begin
         drive_digits(frames[k], 8, gapped, done, vd_pre);
         asserts++; if (!done) begin failures++; $display("FAIL frame%0d_timeout g=%0d got 0 exp 1", k, gapped); end
         asserts++; if (vd_pre !== 1'b0) begin failures++; $display("FAIL frame%0d_vd_early got %b exp 0", k, vd_pre); end
         asserts++; if (word_vd !== 1'b1) begin failures++; $display("FAIL frame%0d_word_vd got %b exp 1", k, word_vd); end
         asserts++; if (word_out !== expw[k]) begin failures++; $display("FAIL frame%0d_word g=%0d got %h exp %h", k, gapped, word_out, expw[k]); end
         asserts++; if (Out_rd !== 1'b0) begin failures++; $display("FAIL frame%0d_out_rd got %b exp 0", k, Out_rd); end
         asserts++; if (digit_err !== 1'b0) begin failures++; $display("FAIL frame%0d_err got %b exp 0", k, digit_err); end
         release_word();
         asserts++; if (word_vd !== 1'b0 || Out_rd !== 1'b1) begin failures++; $display("FAIL frame%0d_release got vd=%b rd=%b exp vd=0 rd=1", k, word_vd, Out_rd); end
      end
   endtask

   task automatic test_backpressure();
      bit   done;
      logic vd_pre;
      drive_digits(16'h4000, 8, 1'b0, done, vd_pre);
      asserts++; if (!done) begin failures++; $display("FAIL bp_first_timeout got 0 exp 1"); end
      digit_in = 2'b01;
      Out_vd   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         asserts++; if (word_vd !== 1'b1 || word_out !== 9'h080 || Out_rd !== 1'b0) begin
            failures++; $display("FAIL bp_hold_c%0d got vd=%b w=%h rd=%b exp vd=1 w=080 rd=0", c, word_vd, word_out, Out_rd);
         end
      end
      word_rd = 1'b1;
      @(posedge clk); #1;
      word_rd = 1'b0;
      asserts++; if (Out_rd !== 1'b1 || word_vd !== 1'b0) begin failures++; $display("FAIL bp_release got rd=%b vd=%b exp rd=1 vd=0", Out_rd, word_vd); end
      drive_digits(16'h7000, 8, 1'b0, done, vd_pre);
      asserts++; if (!done || word_out !== 9'h040) begin failures++; $display("FAIL bp_next_frame got %h exp 040", word_out); end
      release_word();
   endtask

   task automatic test_illegal();
      bit   done;
      logic vd_pre;
      drive_digits(16'h0800, 8, 1'b0, done, vd_pre);
      asserts++; if (!done || word_out !== 9'h000) begin failures++; $display("FAIL illegal_word got %h exp 000", word_out); end
      asserts++; if (digit_err !== 1'b1 || word_vd !== 1'b1) begin failures++; $display("FAIL illegal_err got err=%b vd=%b exp err=1 vd=1", digit_err, word_vd); end
      release_word();
      asserts++; if (digit_err !== 1'b0) begin failures++; $display("FAIL illegal_err_clear got %b exp 0", digit_err); end
   endtask

   task automatic test_frame_clr();
      bit   done;
      logic vd_pre;
      drive_digits(16'h5400, 3, 1'b0, done, vd_pre);
      digit_in  = 2'b01;
      Out_vd    = 1'b1;
      frame_clr = 1'b1;
      @(posedge clk); #1;
      frame_clr = 1'b0;
      Out_vd    = 1'b0;
      asserts++; if (Out_rd !== 1'b1 || word_vd !== 1'b0) begin failures++; $display("FAIL clr_state got rd=%b vd=%b exp rd=1 vd=0", Out_rd, word_vd); end
      drive_digits(16'h0003, 8, 1'b0, done, vd_pre);
      asserts++; if (!done || word_out !== 9'h1FF) begin failures++; $display("FAIL clr_next_frame got %h exp 1FF", word_out); end
      // abort a held word while word_rd is also asserted
      word_rd   = 1'b1;
      frame_clr = 1'b1;
      @(posedge clk); #1;
      word_rd   = 1'b0;
      frame_clr = 1'b0;
      asserts++; if (word_vd !== 1'b0 || Out_rd !== 1'b1) begin failures++; $display("FAIL clr_hold got vd=%b rd=%b exp vd=0 rd=1", word_vd, Out_rd); end
      drive_digits(16'h4000, 8, 1'b0, done, vd_pre);
      asserts++; if (!done || word_out !== 9'h080) begin failures++; $display("FAIL clr_after_hold got %h exp 080", word_out); end
      release_word();
   endtask

   task automatic test_async_reset();
      bit   done;
      logic vd_pre;
      drive_digits(16'h9400, 3, 1'b0, done, vd_pre);
      asserts++; if (digit_err !== 1'b1) begin failures++; $display("FAIL ar_err_before got %b exp 1", digit_err); end
      reset_n = 1'b0;
      #1;
      asserts++; if (Out_rd !== 1'b0 || word_vd !== 1'b0 || word_out !== 9'h0 || digit_err !== 1'b0) begin
         failures++; $display("FAIL ar_outputs got rd=%b vd=%b w=%h err=%b exp all 0", Out_rd, word_vd, word_out, digit_err);
      end
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      drive_digits(16'h4000, 8, 1'b0, done, vd_pre);
      asserts++; if (!done || word_out !== 9'h080) begin failures++; $display("FAIL ar_next_frame got %h exp 080", word_out); end
      release_word();
   endtask

   initial begin
      reset_n   = 1'b0;
      digit_in  = 2'b00;
      Out_vd    = 1'b0;
      frame_clr = 1'b0;
      word_rd   = 1'b0;
      test_reset();
      test_frames(1'b0);
      test_backpressure();
      test_frames(1'b1);
      test_illegal();
      test_frame_clr();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
